// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
//
// Purpose:
//   Fractional baud-rate generator for the UART datapaths. Produces the
//   oversampling tick, a per-bit tick and a mid-bit tick. The s_tick period is
//   div_int+1 cycles, stretched by one cycle whenever the first-order
//   fractional accumulator carries. The long-run average period is therefore
//   div_int+1+div_frac/2^FRAC_W cycles.
//
// Build option:
//   BAUD_FRAC_EN - when defined, the fractional accumulator (acc/ext) is built
//                  and div_frac takes effect. When undefined, div_frac is
//                  ignored, ext is tied 0 and the period is always div_int+1
//                  (legacy integer divider). The port list is the same in
//                  both builds.
//
// Parameters:
//   INT_W     width of the integer divisor
//   FRAC_W    width of the fractional divisor (step = 1/2^FRAC_W cycle)
//   OVS       s_ticks per bit (even, >= 4)
//   RESET_DIV integer divisor active after reset (fraction resets to 0)
//
// Ports:
//   clk       in   system clock, rising edge
//   clear     in   asynchronous active-high reset
//   enable    in   count enable; low freezes all counters and emits no ticks
//   load      in   one-cycle pulse: latch div_int/div_frac, restart counters
//   div_int   in   integer divisor, sampled only when load=1
//   div_frac  in   fractional divisor, sampled only when load=1
//   sync      in   one-cycle pulse: restart counters, keep divisor
//   s_tick    out  oversampling tick, one-cycle pulse, registered
//   bit_tick  out  pulse coincident with every OVS-th s_tick, registered
//   mid_tick  out  pulse coincident with the s_tick ending phase OVS/2-1
//
// Control semantics (all inputs sampled on the rising edge of clk):
//   load or sync high -> counters, accumulator and ticks restart from zero,
//   regardless of enable; load additionally latches the divisor. Otherwise,
//   with enable high the period counter advances; with enable low everything
//   holds and the tick outputs drop to 0.
// -----------------------------------------------------------------------------
module baud_gen_frac #(
  parameter int INT_W     = 16,
  parameter int FRAC_W    = 4,
  parameter int OVS       = 16,
  parameter int RESET_DIV = 26
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              enable,
  input  logic              load,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              sync,
  output logic              s_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
  // The terminal count is div_int_a + ext, which needs one bit more than
  // INT_W when div_int_a is all-ones and ext=1. The period counter is kept
  // the same width so it can actually reach that terminal value instead of
  // wrapping to 0 one cycle early.
  localparam int CNT_W = INT_W + 1;

  localparam logic [OVS_W-1:0] OVS_LAST    = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID     = OVS_W'(OVS / 2 - 1);
  localparam logic [INT_W-1:0] RESET_DIV_V = INT_W'(RESET_DIV);

  // ---------------------------------------------------------------------------
  // Shared control decode
  // ---------------------------------------------------------------------------
  logic restart;   // load or sync: restart every counter this edge
  logic advance;   // normal counting edge
  logic ext;       // one extra cycle in the current period (fraction carry)
  logic at_term;   // period counter sits on its terminal value
  logic tick_now;  // this edge ends a period and emits an s_tick

  logic [CNT_W-1:0] term;

  assign restart  = load | sync;
  assign advance  = enable & ~restart;

  // ---------------------------------------------------------------------------
  // Integer period counter, oversample counter and registered ticks
  // ---------------------------------------------------------------------------
  logic [INT_W-1:0] div_int_q,  div_int_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [OVS_W-1:0] ovs_cnt_q,  ovs_cnt_d;
  logic             s_tick_q,   s_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;

  assign term     = {1'b0, div_int_q} + CNT_W'(ext);
  assign at_term  = (cnt_q == term);
  assign tick_now = advance & at_term;

  always_comb begin
    div_int_d  = div_int_q;
    cnt_d      = cnt_q;
    ovs_cnt_d  = ovs_cnt_q;
    // Ticks are single-cycle: they fall back to 0 unless this edge ends a
    // period, which also covers enable=0 and restart edges.
    s_tick_d   = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;

    if (load) begin
      div_int_d = div_int;
    end

    if (restart) begin
      cnt_d     = '0;
      ovs_cnt_d = '0;
    end else if (enable) begin
      if (at_term) begin
        cnt_d      = '0;
        s_tick_d   = 1'b1;
        // bit/mid decode uses the oversample phase before it advances, so
        // bit_tick lands on the OVS-th s_tick and mid_tick on the OVS/2-th.
        bit_tick_d = (ovs_cnt_q == OVS_LAST);
        mid_tick_d = (ovs_cnt_q == OVS_MID);
        ovs_cnt_d  = (ovs_cnt_q == OVS_LAST) ? '0 : ovs_cnt_q + OVS_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      div_int_q  <= RESET_DIV_V;
      cnt_q      <= '0;
      ovs_cnt_q  <= '0;
      s_tick_q   <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      div_int_q  <= div_int_d;
      cnt_q      <= cnt_d;
      ovs_cnt_q  <= ovs_cnt_d;
      s_tick_q   <= s_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign s_tick   = s_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;

  // ---------------------------------------------------------------------------
  // Fractional accumulator
  // ---------------------------------------------------------------------------
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [FRAC_W-1:0] acc_q,      acc_d;
  logic              ext_q,      ext_d;

  always_comb begin
    div_frac_d = div_frac_q;
    acc_d      = acc_q;
    ext_d      = ext_q;

    if (load) begin
      div_frac_d = div_frac;
    end

    if (restart) begin
      acc_d = '0;
      ext_d = 1'b0;
    end else if (tick_now) begin
      // The carry out of the accumulator stretches the next period by one
      // cycle; over 2^FRAC_W periods this adds exactly div_frac cycles.
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac_q};
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      div_frac_q <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
    end else begin
      div_frac_q <= div_frac_d;
      acc_q      <= acc_d;
      ext_q      <= ext_d;
    end
  end

  assign ext = ext_q;
`else
  // Integer-only build: no stretch cycles, div_frac is deliberately ignored.
  logic frac_unused;
  logic tick_unused;

  assign ext         = 1'b0;
  assign frac_unused = ^div_frac;
  assign tick_unused = tick_now;
`endif

endmodule
